// File: rtl/sti_dac_pkg.sv
// sti_dac_pkg: shared types, default geometry and frame-formatting helpers for
// the sti_dac_param serial transmitter / data arrange controller.
//   state_e      : controller state (IDLE / SHIFT / FILL / DONE)
//   DEF_*        : default parameter values of the top level
//   TOTAL        : bytes written to memory for the default geometry
//   ADDR_W/LEN_W : address and length widths for the default geometry
//   format_frame : byte select / zero placement of the parallel input
//   reverse_bits : bit reversal of the low w bits of a frame
package sti_dac_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FILL  = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned DEF_IN_W       = 16;
   localparam int unsigned DEF_MAX_BYTES  = 4;
   localparam int unsigned DEF_NBANK      = 4;
   localparam int unsigned DEF_BANK_DEPTH = 32;
   localparam int unsigned DEF_ROW_BYTES  = 8;

   localparam int unsigned TOTAL  = 2 * DEF_NBANK * DEF_BANK_DEPTH;
   localparam int unsigned ADDR_W = $clog2(DEF_BANK_DEPTH);
   localparam int unsigned LEN_W  = $clog2(DEF_MAX_BYTES);

   // Frames are formatted in a fixed-width container; only the low w bits matter.
   localparam int unsigned FMT_W  = 64;
   localparam int unsigned FMT_IW = $clog2(FMT_W);

   // Width helper that never returns zero, so single-entry geometries still
   // get a 1-bit field.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // data must be zero above in_w. Result holds the w-bit frame in bits [w-1:0].
   function automatic logic [FMT_W-1:0] format_frame(input logic [FMT_W-1:0] data,
                                                     input int unsigned     in_w,
                                                     input int unsigned     w,
                                                     input logic            fill,
                                                     input logic            low);
      logic [FMT_W-1:0] mask;
      logic [FMT_W-1:0] res;
      mask = (FMT_W'(1) << w) - FMT_W'(1);
      if (w < in_w) begin
         res = low ? (data >> (in_w - w)) : (data & mask);
      end else if (w == in_w) begin
         res = data;
      end else begin
         res = fill ? (data << (w - in_w)) : data;
      end
      return res;
   endfunction

   function automatic logic [FMT_W-1:0] reverse_bits(input logic [FMT_W-1:0] f,
                                                     input int unsigned     w);
      logic [FMT_W-1:0] r;
      int unsigned      j;
      r = '0;
      j = 0;
      for (int unsigned i = 0; i < FMT_W; i++) begin
         if (i < w) begin
            j = w - 1 - i;
            r[j[FMT_IW-1:0]] = f[i];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/sti_bank_map.sv
// sti_bank_map: combinational mapping of the running byte counter onto the
// odd/even bank pairs in a checkerboard layout.
//   cnt  : byte index, 0 .. 2*NBANK*BANK_DEPTH-1
//   pair : bank pair receiving the byte
//   odd  : 1 = odd bank of the pair, 0 = even bank
//   addr : entry address inside the bank
module sti_bank_map
   import sti_dac_pkg::*;
#(
   parameter int unsigned NBANK      = DEF_NBANK,
   parameter int unsigned BANK_DEPTH = DEF_BANK_DEPTH,
   parameter int unsigned ROW_BYTES  = DEF_ROW_BYTES
) (
   input  logic [$clog2(2*NBANK*BANK_DEPTH)-1:0] cnt,
   output logic [clog2_min1(NBANK)-1:0]          pair,
   output logic                                  odd,
   output logic [clog2_min1(BANK_DEPTH)-1:0]     addr
);

   localparam int unsigned CNT_W  = $clog2(2 * NBANK * BANK_DEPTH);
   localparam int unsigned LOC_W  = $clog2(2 * BANK_DEPTH);
   localparam int unsigned ROW_SH = $clog2(ROW_BYTES);

   logic row_lsb;

   // All geometry values are powers of two, so divide/modulo are bit slices.
   if (NBANK > 1) begin : g_pair
      assign pair = cnt[CNT_W-1:LOC_W];
   end else begin : g_single
      assign pair = '0;
   end

   // A row wider than one bank pair never changes parity inside the pair.
   if (ROW_SH < LOC_W) begin : g_row
      assign row_lsb = cnt[ROW_SH];
   end else begin : g_row_wide
      assign row_lsb = 1'b0;
   end

   assign addr = cnt[LOC_W-1:1];
   // Checkerboard: byte parity flips its bank on every other row.
   assign odd  = (cnt[0] == row_lsb);

endmodule

// File: rtl/sti_dac_param.sv
// sti_dac_param: parallel-to-serial transmitter that also arranges the sent
// bytes into NBANK odd/even memory bank pairs, with end-of-data zero fill.
//   clk, reset           : clock, synchronous active-high reset
//   load, pi_*           : frame strobe and formatting controls (busy=0 only)
//   pi_end               : no more frames, zero-fill the remaining memory
//   busy                 : frame, fill or done in progress
//   so_data, so_valid    : serial output, one bit per cycle
//   oem_dataout/oem_addr : memory write data and address
//   odd_wr, even_wr      : one-hot bank write strobes
//   oem_finish           : single pulse once every memory byte is written
module sti_dac_param
   import sti_dac_pkg::*;
#(
   parameter int unsigned IN_W       = DEF_IN_W,
   parameter int unsigned MAX_BYTES  = DEF_MAX_BYTES,
   parameter int unsigned NBANK      = DEF_NBANK,
   parameter int unsigned BANK_DEPTH = DEF_BANK_DEPTH,
   parameter int unsigned ROW_BYTES  = DEF_ROW_BYTES
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                load,
   input  logic [IN_W-1:0]                     pi_data,
   input  logic [clog2_min1(MAX_BYTES)-1:0]    pi_length,
   input  logic                                pi_fill,
   input  logic                                pi_low,
   input  logic                                pi_msb,
   input  logic                                pi_end,
   output logic                                busy,
   output logic                                so_data,
   output logic                                so_valid,
   output logic [7:0]                          oem_dataout,
   output logic [clog2_min1(BANK_DEPTH)-1:0]   oem_addr,
   output logic [NBANK-1:0]                    odd_wr,
   output logic [NBANK-1:0]                    even_wr,
   output logic                                oem_finish
);

   localparam int unsigned FRAME_W  = 8 * MAX_BYTES;
   localparam int unsigned P_TOTAL  = 2 * NBANK * BANK_DEPTH;
   localparam int unsigned P_ADDR_W = clog2_min1(BANK_DEPTH);
   localparam int unsigned PAIR_W   = clog2_min1(NBANK);
   // One extra bit so the counter can sit at P_TOTAL after the last write.
   localparam int unsigned CNT_W    = $clog2(P_TOTAL) + 1;
   localparam int unsigned BITS_W   = $clog2(FRAME_W + 1);

   state_e state_q, state_d;
   logic   busy_q;
   logic   end_pend_q;

   logic [FRAME_W-1:0]  shreg_q;   // frame left-aligned; MSB is the bit on so_data
   logic [BITS_W-1:0]   bits_q;    // serial bits still to send, including current
   logic [2:0]          bitpos_q;
   logic [6:0]          byte_q;    // first 7 bits of the byte being assembled
   logic [CNT_W-1:0]    cnt_q;
   logic                fin_sent_q;

   logic [7:0]          data_q;
   logic [P_ADDR_W-1:0] addr_q;
   logic [NBANK-1:0]    odd_q, even_q;
   logic                finish_q;

   logic                shifting, byte_done, cnt_room, fire, accept, finish_d;
   logic [7:0]          wr_byte;
   logic [NBANK-1:0]    odd_d, even_d;
   logic [PAIR_W-1:0]   map_pair;
   logic                map_odd;
   logic [P_ADDR_W-1:0] map_addr;
   int unsigned         frame_w;
   logic [FMT_W-1:0]    fmt;
   logic [FRAME_W-1:0]  frame_al;

   sti_bank_map #(
      .NBANK      (NBANK),
      .BANK_DEPTH (BANK_DEPTH),
      .ROW_BYTES  (ROW_BYTES)
   ) u_bank_map (
      .cnt  (cnt_q[CNT_W-2:0]),
      .pair (map_pair),
      .odd  (map_odd),
      .addr (map_addr)
   );

   // Frame formatting at load time.
   always_comb begin
      frame_w = (32'(pi_length) + 32'd1) << 3;
      fmt     = format_frame(FMT_W'(pi_data), IN_W, frame_w, pi_fill, pi_low);
      if (!pi_msb) begin
         fmt = reverse_bits(fmt, frame_w);
      end
      frame_al = FRAME_W'(fmt << (FRAME_W - frame_w));
   end

   always_comb begin
      accept    = (state_q == IDLE) && load;
      shifting  = (state_q == SHIFT) && (bits_q != '0);
      byte_done = shifting && (bitpos_q == 3'd7);
      cnt_room  = (cnt_q < CNT_W'(P_TOTAL));
      // Once the memory is full, strobes stop but the frame keeps shifting.
      fire      = cnt_room && (byte_done || (state_q == FILL));
      wr_byte   = (state_q == FILL) ? 8'h00 : {byte_q, shreg_q[FRAME_W-1]};
      finish_d  = (cnt_q == CNT_W'(P_TOTAL)) && !fin_sent_q;
      odd_d     = '0;
      even_d    = '0;
      for (int unsigned i = 0; i < NBANK; i++) begin
         odd_d[i]  = fire && map_odd && (map_pair == PAIR_W'(i));
         even_d[i] = fire && !map_odd && (map_pair == PAIR_W'(i));
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (load) begin
               state_d = SHIFT;
            end else if (pi_end) begin
               state_d = FILL;
            end
         end
         SHIFT: begin
            // Leave one cycle after the last byte strobe.
            if (bits_q == '0) begin
               if (!cnt_room) begin
                  state_d = DONE;
               end else if (end_pend_q) begin
                  state_d = FILL;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         FILL: begin
            if (cnt_q >= CNT_W'(P_TOTAL - 1)) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs.
   always_comb begin
      busy        = busy_q;
      so_valid    = shifting;
      so_data     = shifting & shreg_q[FRAME_W-1];
      oem_dataout = data_q;
      oem_addr    = addr_q;
      odd_wr      = odd_q;
      even_wr     = even_q;
      oem_finish  = finish_q;
   end

   // Datapath and registered memory-side outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg_q    <= '0;
         bits_q     <= '0;
         bitpos_q   <= '0;
         byte_q     <= '0;
         end_pend_q <= 1'b0;
         cnt_q      <= '0;
         fin_sent_q <= 1'b0;
         data_q     <= '0;
         addr_q     <= '0;
         odd_q      <= '0;
         even_q     <= '0;
         finish_q   <= 1'b0;
      end else begin
         if (accept) begin
            shreg_q  <= frame_al;
            bits_q   <= BITS_W'(frame_w);
            bitpos_q <= '0;
            byte_q   <= '0;
         end else if (shifting) begin
            shreg_q  <= shreg_q << 1;
            bits_q   <= bits_q - BITS_W'(1);
            bitpos_q <= bitpos_q + 3'd1;
            byte_q   <= {byte_q[5:0], shreg_q[FRAME_W-1]};
         end

         if (accept) begin
            end_pend_q <= pi_end;
         end else if ((state_q == SHIFT) && (bits_q == '0)) begin
            end_pend_q <= 1'b0;
         end

         cnt_q      <= cnt_q + CNT_W'(fire);
         data_q     <= fire ? wr_byte : 8'h00;
         addr_q     <= fire ? map_addr : '0;
         odd_q      <= odd_d;
         even_q     <= even_d;
         finish_q   <= finish_d;
         fin_sent_q <= fin_sent_q | finish_d;
      end
   end

endmodule

// File: tb/tb_sti_dac_param.sv
module tb_sti_dac_param;

   localparam int TOTAL_B = 256;

   logic        clk = 1'b0;
   logic        reset, load, pi_fill, pi_low, pi_msb, pi_end;
   logic [15:0] pi_data;
   logic [1:0]  pi_length;
   logic        busy, so_data, so_valid, oem_finish;
   logic [7:0]  oem_dataout;
   logic [4:0]  oem_addr;
   logic [3:0]  odd_wr, even_wr;

   int n_tests   = 0;
   int n_fails   = 0;
   int model_cnt = 0;
   int frame_no  = 0;

   sti_dac_param #(
      .IN_W       (16),
      .MAX_BYTES  (4),
      .NBANK      (4),
      .BANK_DEPTH (32),
      .ROW_BYTES  (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .pi_data     (pi_data),
      .pi_length   (pi_length),
      .pi_fill     (pi_fill),
      .pi_low      (pi_low),
      .pi_msb      (pi_msb),
      .pi_end      (pi_end),
      .busy        (busy),
      .so_data     (so_data),
      .so_valid    (so_valid),
      .oem_dataout (oem_dataout),
      .oem_addr    (oem_addr),
      .odd_wr      (odd_wr),
      .even_wr     (even_wr),
      .oem_finish  (oem_finish)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

   // {busy, so_valid, so_data, oem_finish, odd_wr, even_wr, oem_addr, oem_dataout}
   function automatic logic [24:0] obs_vec();
      return {busy, so_valid, so_data, oem_finish, odd_wr, even_wr, oem_addr, oem_dataout};
   endfunction

   task automatic check(input string tag, input logic [24:0] got, input logic [24:0] want);
      n_tests++;
      assert (got === want) else begin
         n_fails++;
         $error("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // Checkerboard placement of byte n: {odd_wr, even_wr, addr}.
   function automatic logic [12:0] place(input int n);
      int         pair, loc, row;
      logic [3:0] m;
      pair = n / 64;
      loc  = n % 64;
      row  = loc / 8;
      m    = 4'b0001 << pair;
      if ((n % 2) == (row % 2)) return {m, 4'b0000, 5'(loc / 2)};
      else                      return {4'b0000, m, 5'(loc / 2)};
   endfunction

   task automatic do_reset();
      reset = 1'b1; load = 1'b0; pi_end = 1'b0;
      pi_data = '0; pi_length = '0; pi_fill = 1'b0; pi_low = 1'b0; pi_msb = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("reset_state", obs_vec(), 25'd0);
      reset = 1'b0;
      model_cnt = 0;
   endtask

   // Entered at a negedge with the DUT idle; returns at the negedge after the
   // cycle in which busy should have fallen (or stayed high for fill/done).
   task automatic send_frame(input logic [15:0] d, input int len, input bit fill_b,
                             input bit low_b, input bit msb_b, input bit end_b,
                             input bit hold);
      int          w, fin_at, k;
      logic [31:0] d32, fr, rv;
      logic [12:0] pl;
      logic [7:0]  ed;
      logic        bsy, vld, bit_e;
      w   = 8 * (len + 1);
      d32 = {16'h0000, d};
      if (w < 16)       fr = low_b ? (d32 >> (16 - w)) : (d32 & ((32'd1 << w) - 32'd1));
      else if (w == 16) fr = d32;
      else              fr = fill_b ? (d32 << (w - 16)) : d32;
      if (!msb_b) begin
         rv = '0;
         for (int i = 0; i < w; i++) rv[w-1-i] = fr[i];
         fr = rv;
      end
      frame_no++;
      load = 1'b1; pi_data = d; pi_length = 2'(len);
      pi_fill = fill_b; pi_low = low_b; pi_msb = msb_b; pi_end = end_b;
      @(posedge clk);
      @(negedge clk);
      if (hold) begin
         pi_data = 16'($urandom);
         pi_end  = 1'b1;
      end else begin
         load   = 1'b0;
         pi_end = 1'b0;
      end
      fin_at = -1;
      for (int c = 0; c <= w + 1; c++) begin
         pl = 13'd0;
         ed = 8'h00;
         if (c >= 8 && (c % 8) == 0 && c <= w && model_cnt < TOTAL_B) begin
            k = c / 8 - 1;
            for (int j = 0; j < 8; j++) ed[7-j] = fr[w-1-(8*k+j)];
            pl = place(model_cnt);
            model_cnt++;
            if (model_cnt == TOTAL_B) fin_at = c + 1;
         end
         if (pl == 13'd0) ed = 8'h00;
         vld   = (c < w);
         bit_e = vld ? fr[w-1-c] : 1'b0;
         bsy   = (c <= w) || (model_cnt >= TOTAL_B) || end_b;
         check($sformatf("frame%0d_c%0d", frame_no, c), obs_vec(),
               {bsy, vld, bit_e, (c == fin_at), pl, ed});
         if (c < w + 1) @(negedge clk);
      end
      load   = 1'b0;
      pi_end = 1'b0;
   endtask

   // DONE: busy held, nothing else moves, new requests are ignored.
   task automatic done_hold(input int n, input string tag);
      load = 1'b1; pi_end = 1'b1; pi_data = 16'($urandom);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check($sformatf("%s_%0d", tag, i), obs_vec(), {1'b1, 24'd0});
      end
      load = 1'b0; pi_end = 1'b0;
   endtask

   // Called one cycle after the controller entered fill.
   task automatic run_fill(input string tag);
      while (model_cnt < TOTAL_B) begin
         @(negedge clk);
         check($sformatf("%s_cnt%0d", tag, model_cnt), obs_vec(),
               {4'b1000, place(model_cnt), 8'h00});
         model_cnt++;
      end
      @(negedge clk);
      check({tag, "_finish"}, obs_vec(), {4'b1001, 21'd0});
      done_hold(4, {tag, "_done"});
   endtask

   initial begin
      // Phase 1: directed frames from reset, then randomized traffic.
      do_reset();
      send_frame(16'hA5C3, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      send_frame(16'h8001, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(16'h1234, 3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      send_frame(16'h1234, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      while (model_cnt < 70) begin
         send_frame(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                    1'($urandom), 1'($urandom), 1'b0, 1'($urandom));
      end
      // load and pi_end together: frame goes out, then the rest is zero-filled.
      send_frame(16'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'b1, 1'b0);
      run_fill("fill_after_frame");

      // Phase 2: pi_end alone after three bytes -> 253 zero writes.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         send_frame(16'($urandom), 0, 1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      end
      pi_end = 1'b1;
      @(negedge clk);
      check("fill_entry", obs_vec(), {1'b1, 24'd0});
      pi_end = 1'b0;
      run_fill("fill_idle");

      // Phase 3: memory overflows through frames; tail bits still shift out.
      do_reset();
      send_frame(16'($urandom), 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      while (model_cnt < TOTAL_B) begin
         send_frame(16'($urandom), 3, 1'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0);
      end
      done_hold(12, "overflow_done");

      // Phase 4: reset in the middle of a frame, then counting restarts at 0.
      do_reset();
      load = 1'b1; pi_data = 16'hBEEF; pi_length = 2'd3;
      pi_fill = 1'b1; pi_low = 1'b0; pi_msb = 1'b1;
      @(negedge clk);
      load = 1'b0;
      repeat (12) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("reset_mid_frame", obs_vec(), 25'd0);
      reset = 1'b0;
      model_cnt = 0;
      send_frame(16'hC35A, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(16'h00FF, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
